// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, instruction word layout and sequencer states.
// Used by the CU, the instruction sequencer and the benches.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 3;
  localparam int INSTR_W = OP_W + 2 * DATA_W;

  localparam int OP_HI = 18;
  localparam int OP_LO = 16;
  localparam int A_HI  = 15;
  localparam int A_LO  = 8;
  localparam int B_HI  = 7;
  localparam int B_LO  = 0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_INC = 3'b011,
    OP_DEC = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } seq_state_e;

  function automatic op_e instr_op(input instr_t word);
    return op_e'(word[OP_HI:OP_LO]);
  endfunction

  function automatic instr_t make_instr(input op_e op, input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Host/CU bundle for the instruction sequencer. master = host plus CU side,
// slave = the sequencer itself.
interface alu_instr_sequencer_if #(
  parameter int DEPTH = 8
);
  import alu_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic                  load_en;
  logic [AW-1:0]         load_addr;
  instr_t                load_instr;
  logic                  start;
  logic [AW:0]           prog_len;
  instr_t                instr_out;
  logic                  instr_valid;
  logic [DATA_W-1:0]     alu_result;
  logic                  res_valid;
  logic [DATA_W-1:0]     res_data;
  logic [AW-1:0]         res_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output load_en, load_addr, load_instr, start, prog_len, alu_result,
    input  instr_out, instr_valid, res_valid, res_data, res_idx, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_instr, start, prog_len, alu_result,
    output instr_out, instr_valid, res_valid, res_data, res_idx, busy, done
  );

endinterface

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x instruction register file, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module alu_prog_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  instr_t        wdata,
  input  logic [AW-1:0] raddr,
  output instr_t        rdata
);

  instr_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Steps a stored program through the combinational CU one slot at a time and
// returns each settled result tagged with its slot index.
module alu_instr_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int RES_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_instr_sequencer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RES_LAT < 2) ? 1 : $clog2(RES_LAT + 1);

  seq_state_e        state_reg;
  logic [AW:0]       pc_reg;
  logic [AW:0]       len_reg;
  logic [CW-1:0]     cnt_reg;
  instr_t            instr_reg;
  logic              instr_valid_reg;
  logic              res_valid_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic [AW-1:0]     res_idx_reg;
  logic              busy_reg;
  logic              done_reg;

  instr_t            mem_rdata;
  logic [AW:0]       len_clamped;
  logic              more_slots;

  // Writes are locked out for the whole run so the program cannot change under it.
  alu_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (bus.load_en && !busy_reg),
    .waddr (bus.load_addr),
    .wdata (bus.load_instr),
    .raddr (pc_reg[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign len_clamped = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;
  assign more_slots  = (pc_reg < (len_reg - (AW+1)'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= '0;
      len_reg         <= '0;
      cnt_reg         <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_data_reg    <= '0;
      res_idx_reg     <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (len_clamped != '0) begin
              len_reg   <= len_clamped;
              pc_reg    <= '0;
              busy_reg  <= 1'b1;
              state_reg <= ST_ISSUE;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          instr_reg <= mem_rdata;
          if (instr_op(mem_rdata) == OP_NOP) begin
            // NOP slots are skipped without a settle window or a result.
            instr_valid_reg <= 1'b0;
            pc_reg          <= pc_reg + (AW+1)'(1);
            state_reg       <= more_slots ? ST_ISSUE : ST_FINISH;
          end else begin
            instr_valid_reg <= 1'b1;
            cnt_reg         <= CW'(RES_LAT);
            state_reg       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            res_data_reg  <= bus.alu_result;
            res_idx_reg   <= pc_reg[AW-1:0];
            res_valid_reg <= 1'b1;
            pc_reg        <= pc_reg + (AW+1)'(1);
            state_reg     <= more_slots ? ST_ISSUE : ST_FINISH;
          end
        end
        ST_FINISH: begin
          instr_valid_reg <= 1'b0;
          busy_reg        <= 1'b0;
          done_reg        <= 1'b1;
          state_reg       <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr_out   = instr_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.res_valid   = res_valid_reg;
  assign bus.res_data    = res_data_reg;
  assign bus.res_idx     = res_idx_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: RES_LAT=1 and RES_LAT=3 instances share one
// stimulus stream, each with its own CU model and result scoreboard queue.
module tb_alu_instr_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_instr_sequencer_if #(.DEPTH(DEPTH)) bus1 ();
  alu_instr_sequencer_if #(.DEPTH(DEPTH)) bus3 ();

  alu_instr_sequencer #(.DEPTH(DEPTH), .RES_LAT(LAT0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_instr_sequencer #(.DEPTH(DEPTH), .RES_LAT(LAT1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic [7:0] cu_model(input logic [18:0] w);
    logic [7:0] a, b;
    a = w[15:8];
    b = w[7:0];
    case (w[18:16])
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a + 8'd1;
      3'b100:  return a - 8'd1;
      3'b101:  return a & b;
      3'b110:  return a | b;
      3'b111:  return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign bus1.alu_result = cu_model(bus1.instr_out);
  assign bus3.alu_result = cu_model(bus3.instr_out);
  assign bus3.load_en    = bus1.load_en;
  assign bus3.load_addr  = bus1.load_addr;
  assign bus3.load_instr = bus1.load_instr;
  assign bus3.start      = bus1.start;
  assign bus3.prog_len   = bus1.prog_len;

  int          n_checks;
  int          n_fail;
  logic [11:0] q1[$];
  logic [11:0] q3[$];
  instr_t      shadow [DEPTH];
  logic [7:0]  exp1 [7];
  int          done_cnt [2];
  int          run_len [2];
  logic        prev_iv [2];
  logic [18:0] prev_io [2];
  logic        prev_rv [2];
  int          tgt0, tgt1;
  bit          gap_chk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic rv, input logic [7:0] rd, input logic [2:0] ri,
                     input logic dn, input logic iv, input logic [18:0] io);
    logic [11:0] e;
    int lat;
    lat = (k == 0) ? LAT0 : LAT1;
    if (iv === 1'b1 && prev_iv[k] === 1'b1 && io === prev_io[k]) run_len[k]++;
    else run_len[k] = (iv === 1'b1) ? 1 : 0;
    prev_iv[k] = iv;
    prev_io[k] = io;
    if (rv !== 1'b0) begin
      e = 12'hFFF;
      if (k == 0) begin
        if (q1.size() > 0) e = q1.pop_front();
      end else begin
        if (q3.size() > 0) e = q3.pop_front();
      end
      check($sformatf("dut%0d_res_idx_data", k), {20'd0, 1'b0, ri, rd}, {20'd0, e});
      check($sformatf("dut%0d_settle_cycles", k), run_len[k], lat + 1);
    end
    check($sformatf("dut%0d_res_done_overlap", k), {31'd0, rv & dn}, 32'd0);
    if (iv === 1'b1) check($sformatf("dut%0d_valid_on_nop", k), {31'd0, io[18:16] == 3'b000}, 32'd0);
    if (dn === 1'b1) begin
      if (gap_chk) check($sformatf("dut%0d_done_after_last", k), {31'd0, prev_rv[k]}, 32'd1);
      done_cnt[k]++;
    end
    prev_rv[k] = rv;
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, bus1.res_valid, bus1.res_data, bus1.res_idx, bus1.done, bus1.instr_valid, bus1.instr_out);
    mon(1, bus3.res_valid, bus3.res_data, bus3.res_idx, bus3.done, bus3.instr_valid, bus3.instr_out);
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [11:0] v);
    q1.push_back(v);
    q3.push_back(v);
  endtask

  task automatic load(input int addr, input instr_t w);
    bus1.load_en    = 1'b1;
    bus1.load_addr  = 3'(addr);
    bus1.load_instr = w;
    shadow[addr]    = w;
    step();
    bus1.load_en = 1'b0;
  endtask

  task automatic start_run(input int len, input bit use_const);
    int n;
    tgt0 = done_cnt[0] + 1;
    tgt1 = done_cnt[1] + 1;
    n = (len > DEPTH) ? DEPTH : len;
    if (use_const) begin
      for (int i = 0; i < 7; i++) push_both({1'b0, 3'(i), exp1[i]});
    end else begin
      for (int i = 0; i < n; i++)
        if (shadow[i][18:16] != 3'b000) push_both({1'b0, 3'(i), cu_model(shadow[i])});
    end
    bus1.start    = 1'b1;
    bus1.prog_len = 4'(len);
    step();
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!(done_cnt[0] >= tgt0 && done_cnt[1] >= tgt1) && i < 80) begin
      step();
      i++;
    end
    check({tag, "_done_seen"}, {31'd0, (done_cnt[0] >= tgt0 && done_cnt[1] >= tgt1)}, 32'd1);
    check({tag, "_all_results"}, q1.size() + q3.size(), 32'd0);
    check({tag, "_busy_after"}, {30'd0, bus1.busy, bus3.busy}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_instr_out1"}, {13'd0, bus1.instr_out}, 32'd0);
    check({tag, "_instr_out3"}, {13'd0, bus3.instr_out}, 32'd0);
    check({tag, "_ctl1"}, {17'd0, bus1.instr_valid, bus1.res_valid, bus1.res_data,
                           bus1.res_idx, bus1.busy, bus1.done}, 32'd0);
    check({tag, "_ctl3"}, {17'd0, bus3.instr_valid, bus3.res_valid, bus3.res_data,
                           bus3.res_idx, bus3.busy, bus3.done}, 32'd0);
  endtask

  initial begin
    int d0, d1;
    n_checks = 0;
    n_fail   = 0;
    gap_chk  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      run_len[k]  = 0;
      prev_iv[k]  = 1'b0;
      prev_io[k]  = '0;
      prev_rv[k]  = 1'b0;
    end
    exp1[0] = 8'h37; exp1[1] = 8'h0F; exp1[2] = 8'h24; exp1[3] = 8'h22;
    exp1[4] = 8'h00; exp1[5] = 8'h37; exp1[6] = 8'hDC;
    bus1.load_en = 1'b0; bus1.load_addr = '0; bus1.load_instr = '0;
    bus1.start = 1'b0; bus1.prog_len = '0;

    rst_n = 1'b0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;

    // Scenario 1: ops 001..111 on A=23, B=14
    for (int i = 0; i < 7; i++) load(i, make_instr(op_e'(i + 1), 8'h23, 8'h14));
    start_run(7, 1'b1);
    wait_done("s1_full");

    // Scenario 2: NOP in slot 1 is skipped
    load(1, make_instr(OP_NOP, 8'h23, 8'h14));
    start_run(3, 1'b0);
    wait_done("s2_nop");
    load(1, make_instr(OP_SUB, 8'h23, 8'h14));

    // Scenario 3: zero-length run, then an over-long one with a same-cycle load
    gap_chk = 1'b0;
    bus1.start = 1'b1;
    bus1.prog_len = 4'd0;
    step();
    bus1.start = 1'b0;
    check("s3_len0_done", {30'd0, bus1.done, bus3.done}, 32'd3);
    check("s3_len0_busy", {30'd0, bus1.busy, bus3.busy}, 32'd0);
    step();
    check("s3_len0_done_pulse", {30'd0, bus1.done, bus3.done}, 32'd0);
    check("s3_len0_busy_after", {30'd0, bus1.busy, bus3.busy}, 32'd0);
    gap_chk = 1'b1;
    bus1.load_en    = 1'b1;
    bus1.load_addr  = 3'd7;
    bus1.load_instr = make_instr(OP_ADD, 8'h80, 8'h90);
    shadow[7]       = make_instr(OP_ADD, 8'h80, 8'h90);
    start_run(9, 1'b0);
    bus1.load_en = 1'b0;
    wait_done("s3_len9");

    // Scenario 4: load and start mid-run are ignored
    start_run(7, 1'b1);
    step();
    step();
    check("s4_busy_mid", {30'd0, bus1.busy, bus3.busy}, 32'd3);
    bus1.load_en    = 1'b1;
    bus1.load_addr  = 3'd3;
    bus1.load_instr = make_instr(OP_NOP, 8'h00, 8'h00);
    bus1.start      = 1'b1;
    bus1.prog_len   = 4'd2;
    step();
    bus1.load_en = 1'b0;
    bus1.start   = 1'b0;
    wait_done("s4_ignore");

    // Scenario 5: reset on cycle 2 of a run, then a clean restart
    start_run(7, 1'b1);
    step();
    rst_n = 1'b0;
    q1.delete();
    q3.delete();
    step();
    rst_n = 1'b1;
    check_zero("s5_abort");
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    repeat (12) step();
    check("s5_no_done_dut1", done_cnt[0], d0);
    check("s5_no_done_dut3", done_cnt[1], d1);
    start_run(7, 1'b1);
    wait_done("s5_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
